// File: rtl/rs_dispatch_queue.sv
// Three-channel dispatch queue: routes decoded RV32 instructions by major opcode
// into integer, load/store and branch FIFOs that feed the reservation stations.
module rs_dispatch_queue #(
  parameter int  DEPTH  = 4,
  parameter int  DATA_W = 76,
  localparam int E_W    = 32 + DATA_W,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              kill,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [31:0]       in_pc,
  input  logic [DATA_W-1:0] in_payload,
  output logic [2:0]        out_valid,
  input  logic [2:0]        out_ready,
  output logic [3*E_W-1:0]  out_data,
  output logic [3*CW-1:0]   out_count,
  output logic              illegal
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [E_W-1:0] r_mem   [3][DEPTH];
  logic [PW-1:0]  r_head  [3];
  logic [PW-1:0]  r_tail  [3];
  logic [CW-1:0]  r_count [3];
  logic           r_illegal;

  logic           w_legal;
  logic [2:0]     w_chan_oh;
  logic [2:0]     w_full;
  logic [2:0]     w_enq;
  logic [2:0]     w_deq;
  logic           w_accept;
  logic           w_tgt_full;

  always_comb begin
    w_legal   = 1'b1;
    w_chan_oh = 3'b000;
    case (in_opcode)
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: w_chan_oh = 3'b001;
      7'b0000011, 7'b0100011:                         w_chan_oh = 3'b010;
      7'b1100011, 7'b1101111, 7'b1100111:             w_chan_oh = 3'b100;
      default:                                        w_legal   = 1'b0;
    endcase
  end

  // in_ready looks only at registered occupancy, never at out_ready
  assign w_tgt_full = |(w_full & w_chan_oh);
  assign in_ready   = kill ? 1'b0 : (!w_legal ? 1'b1 : !w_tgt_full);
  assign w_accept   = in_valid & in_ready;
  assign w_enq      = {3{w_accept & w_legal}} & w_chan_oh;

  for (genvar g = 0; g < 3; g++) begin : g_chan
    assign w_full[g]                 = (r_count[g] == FULL_CNT);
    assign w_deq[g]                  = (r_count[g] != '0) & out_ready[g];
    assign out_valid[g]              = (r_count[g] != '0);
    assign out_data[g*E_W +: E_W]    = r_mem[g][r_head[g]];
    assign out_count[g*CW +: CW]     = r_count[g];
  end

  assign illegal = r_illegal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < 3; c++) begin
        r_head[c]  <= '0;
        r_tail[c]  <= '0;
        r_count[c] <= '0;
      end
      r_illegal <= 1'b0;
    end else if (kill) begin
      for (int c = 0; c < 3; c++) begin
        r_head[c]  <= '0;
        r_tail[c]  <= '0;
        r_count[c] <= '0;
      end
      r_illegal <= 1'b0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (w_enq[c]) r_tail[c] <= r_tail[c] + PW'(1);
        if (w_deq[c]) r_head[c] <= r_head[c] + PW'(1);
        case ({w_enq[c], w_deq[c]})
          2'b10:   r_count[c] <= r_count[c] + CW'(1);
          2'b01:   r_count[c] <= r_count[c] - CW'(1);
          default: r_count[c] <= r_count[c];
        endcase
      end
      r_illegal <= w_accept & ~w_legal;
    end
  end

  // Storage carries no reset; contents are only observed behind out_valid
  always_ff @(posedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (w_enq[c]) r_mem[c][r_tail[c]] <= {in_pc, in_payload};
    end
  end

endmodule

// File: tb/tb_rs_dispatch_queue.sv
// Bench for rs_dispatch_queue: directed vector table, reset corner sequence,
// then randomized traffic against a queue-based reference model.
module tb_rs_dispatch_queue;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 76;
  localparam int E_W    = 32 + DATA_W;
  localparam int CW     = $clog2(DEPTH + 1);

  localparam logic [6:0] OP_ADD   = 7'b0110011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_FENCE = 7'b0001111;

  logic              clk = 1'b0;
  logic              reset;
  logic              kill;
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_opcode;
  logic [31:0]       in_pc;
  logic [DATA_W-1:0] in_payload;
  logic [2:0]        out_valid;
  logic [2:0]        out_ready;
  logic [3*E_W-1:0]  out_data;
  logic [3*CW-1:0]   out_count;
  logic              illegal;

  rs_dispatch_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .kill(kill),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_pc(in_pc), .in_payload(in_payload),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int chan_of(input logic [6:0] op);
    case (op)
      OP_ADD, OP_ADDI, OP_LUI, OP_AUIPC: return 0;
      OP_LD, OP_ST:                      return 1;
      OP_BR, OP_JAL, OP_JALR:            return 2;
      default:                           return -1;
    endcase
  endfunction

  function automatic logic [CW-1:0] cnt(input int c);
    return out_count[c*CW +: CW];
  endfunction

  function automatic logic [31:0] head_pc(input int c);
    return out_data[c*E_W + DATA_W +: 32];
  endfunction

  // One clock: drive at negedge, sample in_ready before the edge, settle after it
  task automatic cyc(input logic k, input logic v, input logic [6:0] op,
                     input logic [31:0] pc, input logic [2:0] rdy, output logic ir);
    @(negedge clk);
    kill = k; in_valid = v; in_opcode = op; in_pc = pc; out_ready = rdy;
    in_payload = DATA_W'({pc, ~pc, pc ^ 32'h5a5a_a5a5});
    #1 ir = in_ready;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        k, v;
    logic [6:0]  op;
    logic [31:0] pc;
    logic [2:0]  rdy;
    logic        ir;
    logic [2:0]  ov;
    int          c0, c1, c2;
    logic        ill;
    logic [2:0]  pcm;
    logic [31:0] p0, p1, p2;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic k, v, input logic [6:0] op, input logic [31:0] pc,
                     input logic [2:0] rdy, input logic ir, input logic [2:0] ov,
                     input int c0, c1, c2, input logic ill, input logic [2:0] pcm,
                     input logic [31:0] p0, p1, p2);
    vec_t e;
    e.k = k; e.v = v; e.op = op; e.pc = pc; e.rdy = rdy; e.ir = ir; e.ov = ov;
    e.c0 = c0; e.c1 = c1; e.c2 = c2; e.ill = ill; e.pcm = pcm;
    e.p0 = p0; e.p1 = p1; e.p2 = p2;
    tbl.push_back(e);
  endtask

  logic [E_W-1:0] mq[3][$];

  task automatic check_model(input string tag, input logic exp_ill);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("%s_valid%0d", tag, c), 128'(out_valid[c]), 128'(mq[c].size() != 0));
      check($sformatf("%s_count%0d", tag, c), 128'(cnt(c)), 128'(mq[c].size()));
      if (mq[c].size() != 0)
        check($sformatf("%s_data%0d", tag, c), 128'(out_data[c*E_W +: E_W]), 128'(mq[c][0]));
    end
    check({tag, "_illegal"}, 128'(illegal), 128'(exp_ill));
  endtask

  initial begin
    logic ir;
    logic exp_ir, exp_ill;
    int   ch;
    logic [6:0] ops [10];

    reset = 1'b0; kill = 1'b0; in_valid = 1'b0; in_opcode = '0;
    in_pc = '0; in_payload = '0; out_ready = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 128'(out_valid), 128'(0));
    check("rst_count", 128'(out_count), 128'(0));
    check("rst_illegal", 128'(illegal), 128'(0));
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", 128'(out_valid), 128'(0));
    check("post_rst_count", 128'(out_count), 128'(0));

    //  k  v  op        pc      rdy     ir ov      c0 c1 c2 ill pcm     p0      p1      p2
    add(0, 0, OP_ADD,   32'h0,   3'b000, 1, 3'b000, 0, 0, 0, 0, 3'b000, 0,       0,       0);
    add(0, 1, OP_ADD,   32'h100, 3'b000, 1, 3'b001, 1, 0, 0, 0, 3'b001, 32'h100, 0,       0);
    add(0, 0, OP_ADD,   32'h0,   3'b001, 1, 3'b000, 0, 0, 0, 0, 3'b000, 0,       0,       0);
    add(0, 1, OP_LD,    32'h0,   3'b000, 1, 3'b010, 0, 1, 0, 0, 3'b010, 0,       0,       0);
    add(0, 1, OP_LD,    32'h1,   3'b000, 1, 3'b010, 0, 2, 0, 0, 3'b010, 0,       0,       0);
    add(0, 1, OP_LD,    32'h2,   3'b000, 1, 3'b010, 0, 3, 0, 0, 3'b010, 0,       0,       0);
    add(0, 1, OP_LD,    32'h3,   3'b000, 1, 3'b010, 0, 4, 0, 0, 3'b010, 0,       0,       0);
    add(0, 1, OP_LD,    32'h4,   3'b000, 0, 3'b010, 0, 4, 0, 0, 3'b010, 0,       0,       0);
    add(0, 1, OP_LD,    32'h5,   3'b010, 0, 3'b010, 0, 3, 0, 0, 3'b010, 0,       32'h1,   0);
    add(0, 0, OP_LD,    32'h0,   3'b010, 1, 3'b010, 0, 2, 0, 0, 3'b010, 0,       32'h2,   0);
    add(0, 0, OP_LD,    32'h0,   3'b010, 1, 3'b010, 0, 1, 0, 0, 3'b010, 0,       32'h3,   0);
    add(0, 0, OP_LD,    32'h0,   3'b010, 1, 3'b000, 0, 0, 0, 0, 3'b000, 0,       0,       0);
    add(0, 1, OP_BR,    32'h200, 3'b000, 1, 3'b100, 0, 0, 1, 0, 3'b100, 0,       0,       32'h200);
    add(0, 1, OP_ST,    32'h204, 3'b000, 1, 3'b110, 0, 1, 1, 0, 3'b110, 0,       32'h204, 32'h200);
    add(0, 1, OP_ADDI,  32'h208, 3'b000, 1, 3'b111, 1, 1, 1, 0, 3'b111, 32'h208, 32'h204, 32'h200);
    add(0, 1, OP_FENCE, 32'h20c, 3'b000, 1, 3'b111, 1, 1, 1, 1, 3'b111, 32'h208, 32'h204, 32'h200);
    add(0, 0, OP_FENCE, 32'h0,   3'b000, 1, 3'b111, 1, 1, 1, 0, 3'b000, 0,       0,       0);
    add(1, 1, OP_ADD,   32'h210, 3'b000, 0, 3'b000, 0, 0, 0, 0, 3'b000, 0,       0,       0);
    add(0, 1, OP_FENCE, 32'h0,   3'b000, 1, 3'b000, 0, 0, 0, 1, 3'b000, 0,       0,       0);
    add(1, 1, OP_FENCE, 32'h0,   3'b000, 0, 3'b000, 0, 0, 0, 0, 3'b000, 0,       0,       0);
    add(0, 1, OP_JAL,   32'h300, 3'b000, 1, 3'b100, 0, 0, 1, 0, 3'b100, 0,       0,       32'h300);
    add(0, 1, OP_JALR,  32'h304, 3'b100, 1, 3'b100, 0, 0, 1, 0, 3'b100, 0,       0,       32'h304);
    add(0, 1, OP_LUI,   32'h310, 3'b000, 1, 3'b101, 1, 0, 1, 0, 3'b101, 32'h310, 0,       32'h304);
    add(0, 1, OP_AUIPC, 32'h314, 3'b001, 1, 3'b101, 1, 0, 1, 0, 3'b101, 32'h314, 0,       32'h304);
    add(0, 0, OP_AUIPC, 32'h0,   3'b111, 1, 3'b000, 0, 0, 0, 0, 3'b000, 0,       0,       0);

    foreach (tbl[i]) begin
      cyc(tbl[i].k, tbl[i].v, tbl[i].op, tbl[i].pc, tbl[i].rdy, ir);
      check($sformatf("vec%0d_in_ready", i), 128'(ir), 128'(tbl[i].ir));
      check($sformatf("vec%0d_out_valid", i), 128'(out_valid), 128'(tbl[i].ov));
      check($sformatf("vec%0d_count0", i), 128'(cnt(0)), 128'(tbl[i].c0));
      check($sformatf("vec%0d_count1", i), 128'(cnt(1)), 128'(tbl[i].c1));
      check($sformatf("vec%0d_count2", i), 128'(cnt(2)), 128'(tbl[i].c2));
      check($sformatf("vec%0d_illegal", i), 128'(illegal), 128'(tbl[i].ill));
      if (tbl[i].pcm[0]) check($sformatf("vec%0d_pc0", i), 128'(head_pc(0)), 128'(tbl[i].p0));
      if (tbl[i].pcm[1]) check($sformatf("vec%0d_pc1", i), 128'(head_pc(1)), 128'(tbl[i].p1));
      if (tbl[i].pcm[2]) check($sformatf("vec%0d_pc2", i), 128'(head_pc(2)), 128'(tbl[i].p2));
    end

    // Reset dropped mid-cycle with an enqueue and dequeue in flight
    cyc(0, 1, OP_ADD, 32'h400, 3'b000, ir);
    cyc(0, 1, OP_ADD, 32'h404, 3'b000, ir);
    check("pre_mid_rst_count0", 128'(cnt(0)), 128'(2));
    @(negedge clk);
    in_valid = 1'b1; in_opcode = OP_ADD; in_pc = 32'h408; out_ready = 3'b001;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_async_count", 128'(out_count), 128'(0));
    check("mid_rst_async_valid", 128'(out_valid), 128'(0));
    @(posedge clk); #1;
    check("mid_rst_held_valid", 128'(out_valid), 128'(0));
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 3'b000;
    @(posedge clk); #1;
    check("mid_rst_release_valid", 128'(out_valid), 128'(0));
    check("mid_rst_release_count", 128'(out_count), 128'(0));
    cyc(0, 1, OP_ADD, 32'h40c, 3'b000, ir);
    check("resume_valid", 128'(out_valid), 128'(3'b001));
    check("resume_count0", 128'(cnt(0)), 128'(1));
    check("resume_pc0", 128'(head_pc(0)), 128'(32'h40c));

    // Randomized traffic against the queue model, starting from a kill-flushed state
    cyc(1, 0, OP_ADD, 32'h0, 3'b000, ir);
    ops = '{OP_ADD, OP_ADDI, OP_LUI, OP_AUIPC, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_FENCE};
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      kill       = ($urandom_range(0, 59) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      in_opcode  = ($urandom_range(0, 11) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
      in_pc      = $urandom;
      in_payload = DATA_W'({$urandom, $urandom, $urandom});
      out_ready  = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom);
      #1;
      ch = chan_of(in_opcode);
      exp_ir = kill ? 1'b0 : (ch < 0) ? 1'b1 : (mq[ch].size() < DEPTH);
      check("rnd_in_ready", 128'(in_ready), 128'(exp_ir));
      if (kill) begin
        for (int c = 0; c < 3; c++) mq[c].delete();
        exp_ill = 1'b0;
      end else begin
        for (int c = 0; c < 3; c++)
          if (mq[c].size() != 0 && out_ready[c]) void'(mq[c].pop_front());
        if (in_valid && exp_ir && ch >= 0) mq[ch].push_back({in_pc, in_payload});
        exp_ill = in_valid && exp_ir && (ch < 0);
      end
      @(posedge clk); #1;
      check_model("rnd", exp_ill);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rs_dispatch_queue.md
RS_DISPATCH_QUEUE -- requirements
Module: rs_dispatch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, per-channel queue depth (power of 2, >=2).
REQ-002 SHALL have parameter DATA_W, default 76, payload width per instruction.
REQ-003 SHALL define E_W = 32+DATA_W (entry width) and CW = $clog2(DEPTH+1) (count width).
REQ-004 SHALL have port clk, input, 1: clock.
REQ-005 SHALL have port reset, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port kill, input, 1: synchronous flush of all queues.
REQ-007 SHALL have port in_valid, input, 1: decoded instruction present.
REQ-008 SHALL have port in_ready, output, 1: instruction accepted this cycle when high with in_valid.
REQ-009 SHALL have port in_opcode, input, 7: RV32 major opcode.
REQ-010 SHALL have port in_pc, input, 32: instruction PC.
REQ-011 SHALL have port in_payload, input, DATA_W: operands, immediates and control.
REQ-012 SHALL have port out_valid, output, 3: per-channel head valid; bit 0 integer, bit 1 load/store, bit 2 branch.
REQ-013 SHALL have port out_ready, input, 3: per-channel consumer ready.
REQ-014 SHALL have port out_data, output, 3*E_W: per-channel head entry {pc, payload}; channel c at bits [c*E_W +: E_W].
REQ-015 SHALL have port out_count, output, 3*CW: per-channel occupancy; channel c at [c*CW +: CW].
REQ-016 SHALL have port illegal, output, 1: one-cycle pulse flagging a dropped unsupported opcode.

Function
REQ-017 SHALL map opcodes to the integer channel (0): 0110011, 0010011, 0110111, 0010111.
REQ-018 SHALL map opcodes to the load/store channel (1): 0000011, 0100011.
REQ-019 SHALL map opcodes to the branch channel (2): 1100011, 1101111, 1100111.
REQ-020 SHALL treat every other opcode as illegal.
REQ-021 SHALL drive in_ready combinationally: 0 if kill; else 1 for illegal opcodes; else !full[target channel].
REQ-022 SHALL ignore out_ready when computing in_ready: no pass-through, so a full queue rejects input even when it dequeues the same cycle.
REQ-023 SHALL, on in_valid & in_ready with a legal opcode, write {in_pc, in_payload} at the target tail on the clock edge and increment the tail pointer modulo DEPTH.
REQ-024 SHALL, on in_valid & in_ready with an illegal opcode, discard the instruction and assert illegal for exactly the following cycle.
REQ-025 SHALL drive out_valid[c] = (count[c] != 0) and out_data[c] = entry at head[c], both purely from registered state.
REQ-026 SHALL, on out_valid[c] & out_ready[c], advance head[c] modulo DEPTH.
REQ-027 SHALL set enqueue-to-out_valid latency to 1 cycle, with no same-cycle bypass into an empty queue.
REQ-028 SHALL, on a simultaneous enqueue and dequeue on one channel, leave the count unchanged and move both pointers.
REQ-029 SHALL keep entries in FIFO order per channel, with channels independent of one another.
REQ-030 SHALL, when kill=1, at the edge clear every head, tail and count and force illegal to 0, with kill taking priority over enqueue and dequeue that cycle.
REQ-031 SHALL update out_count the cycle after the enqueue/dequeue edge, with range 0..DEPTH.
REQ-032 SHALL treat out_ready while out_valid=0 as a no-op.

Reset
REQ-033 SHALL, on reset low, asynchronously clear all pointers and counts and set illegal=0.
REQ-034 SHALL hold out_valid=0 and out_count=0 while reset is low and in the first cycle after release.
REQ-035 SHALL NOT require storage array contents to be reset; out_data is don't-care while out_valid[c]=0.
REQ-036 SHALL discard any in-flight enqueue or dequeue on reset asserted mid-operation, with the block resuming empty.

Verification
REQ-037 SHALL cover single enqueue: opcode 0110011, pc 0x100 -> next cycle out_valid=001, out_data[0] pc field 0x100, out_count[0]=1.
REQ-038 SHALL cover fill to full: DEPTH=4, five loads 0000011 with out_ready=0 -> in_ready=0 on the fifth, out_count[1]=4, and order pc 0..3 preserved on drain.
REQ-039 SHALL cover full with simultaneous dequeue: load channel count 4, out_ready[1]=1, load offered -> load rejected, count 3 next cycle.
REQ-040 SHALL cover mixed routing: branch 1100011, store 0100011, addi 0010011 back-to-back -> one entry in each channel, out_valid=111.
REQ-041 SHALL cover illegal opcode: 0001111 with in_valid=1 -> in_ready=1, illegal=1 next cycle only, all counts unchanged.
REQ-042 SHALL cover kill: all three channels non-empty, kill=1 with in_valid=1 -> in_ready=0, and next cycle all counts 0 and out_valid=000.
